// File: rtl/regfile_access_master_pkg.sv
// Shared types for the register-file access master: register enum, FSM states, default width.
package regfile_access_master_pkg;

  localparam int REG_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    REG0, REG1, REG2, REG3, REG4, REG5, REG6, REG7
  } reg_e;

  typedef enum logic [1:0] {
    IDLE, ACCESS, RESP
  } master_state_e;

endpackage

// File: rtl/regfile_access_master_if.sv
// Host command/response channel plus register-file port, bundled for the access master.
interface regfile_access_master_if
  import regfile_access_master_pkg::*;
#(
  parameter int REG_WIDTH = REG_WIDTH_DEF
) ();

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  reg_e                 req_addr;
  logic [REG_WIDTH-1:0] req_wdata;
  logic                 resp_valid;
  logic [REG_WIDTH-1:0] resp_rdata;
  logic                 resp_err;
  logic                 RegWrite;
  reg_e                 addr;
  logic [REG_WIDTH-1:0] write_data;
  logic [REG_WIDTH-1:0] read_data;
  logic                 valid;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, read_data, valid,
    output req_ready, resp_valid, resp_rdata, resp_err, RegWrite, addr, write_data
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, read_data, valid,
    input  req_ready, resp_valid, resp_rdata, resp_err, RegWrite, addr, write_data
  );

endinterface

// File: rtl/regfile_timeout_ctr.sv
// Access-wait cycle counter; only built when REGFILE_MASTER_TIMEOUT_EN is defined.
`ifdef REGFILE_MASTER_TIMEOUT_EN
module regfile_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16,
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/regfile_access_master.sv
// Serialises host read/write commands onto the register-file port, one access in flight.
// Optional access timeout enabled by defining REGFILE_MASTER_TIMEOUT_EN.
module regfile_access_master
  import regfile_access_master_pkg::*;
#(
  parameter int REG_WIDTH      = REG_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  regfile_access_master_if.master  bus
);

  master_state_e        state_q, state_d;
  reg_e                 addr_q, addr_d;
  logic [REG_WIDTH-1:0] wdata_q, wdata_d;
  logic [REG_WIDTH-1:0] rdata_q, rdata_d;
  logic                 regwrite_q, regwrite_d;
  logic                 err_q, err_d;
  logic                 expired;

`ifdef REGFILE_MASTER_TIMEOUT_EN
  regfile_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == IDLE),
    .enable  ((state_q == ACCESS) && !bus.valid),
    .expired (expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign expired            = 1'b0;
`endif

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.RegWrite   = regwrite_q;
  assign bus.addr       = addr_q;
  assign bus.write_data = wdata_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    regwrite_d = regwrite_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d     = bus.req_addr;
          wdata_d    = bus.req_wdata;
          regwrite_d = bus.req_write;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        // valid beats expiry when both land on the same cycle
        if (bus.valid) begin
          rdata_d    = regwrite_q ? '0 : bus.read_data;
          err_d      = 1'b0;
          regwrite_d = 1'b0;
          state_d    = RESP;
        end else if (expired) begin
          rdata_d    = '0;
          err_d      = 1'b1;
          regwrite_d = 1'b0;
          state_d    = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= REG0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      regwrite_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      regwrite_q <= regwrite_d;
      err_q      <= err_d;
    end
  end

endmodule
